// File: rtl/sched_dp_pkg.sv
// sched_dp_pkg
//   Shared types and helpers for the programmable scheduled datapath engine.
//   Holds the ALU/MUL opcode enums, the sequencer state enum, the width
//   helpers and the bit offsets of every field of an instruction word.
//   Instruction layout, MSB to LSB:
//     alu_s1, alu_s2, mul_s1, mul_s2 (SELW each), alu_op[1:0], mul_op,
//     alu_we, alu_dst(RW), mul_we, mul_dst(RW), res_we, res_src(RW), last
package sched_dp_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic {
        MUL_MUL = 1'b0,
        MUL_DIV = 1'b1
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DIVW,
        ST_DONE
    } state_e;

    typedef enum int {
        F_LAST, F_RES_SRC, F_RES_WE, F_MUL_DST, F_MUL_WE, F_ALU_DST, F_ALU_WE,
        F_MUL_OP, F_ALU_OP, F_MUL_S2, F_MUL_S1, F_ALU_S2, F_ALU_S1
    } field_e;

    function automatic int sel_width(input int nin, input int nreg);
        return $clog2(nin + nreg);
    endfunction

    function automatic int instr_width(input int selw, input int rw);
        return 4 * selw + 3 * rw + 7;
    endfunction

    // LSB position of each instruction field, counted from bit 0 (last)
    function automatic int field_off(input field_e f, input int selw, input int rw);
        case (f)
            F_LAST:    return 0;
            F_RES_SRC: return 1;
            F_RES_WE:  return 1 + rw;
            F_MUL_DST: return 2 + rw;
            F_MUL_WE:  return 2 + 2 * rw;
            F_ALU_DST: return 3 + 2 * rw;
            F_ALU_WE:  return 3 + 3 * rw;
            F_MUL_OP:  return 4 + 3 * rw;
            F_ALU_OP:  return 5 + 3 * rw;
            F_MUL_S2:  return 7 + 3 * rw;
            F_MUL_S1:  return 7 + 3 * rw + selw;
            F_ALU_S2:  return 7 + 3 * rw + 2 * selw;
            F_ALU_S1:  return 7 + 3 * rw + 3 * selw;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/sched_dp_divider.sv
// sched_dp_divider
//   Iterative restoring unsigned divider, one quotient bit per clock.
//   A start pulse loads the operands; valid pulses DW+1 cycles later with the
//   quotient. A zero divisor finishes on the next cycle with an all-ones
//   quotient and div_zero set. div_zero holds until the next start.
//   Only built when SCHED_DP_DIV_EN is defined.
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-low reset
//   start     load dividend/divisor and begin
//   dividend  numerator
//   divisor   denominator
//   quotient  result, valid when valid is high
//   valid     one-cycle completion pulse
//   div_zero  the current/last division had a zero divisor
`ifdef SCHED_DP_DIV_EN
module sched_dp_divider #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic          valid,
    output logic          div_zero
);

    localparam int CNTW = $clog2(DW + 1);

    logic [DW-1:0]   rem;
    logic [DW-1:0]   dvs;
    logic [CNTW-1:0] cnt;
    logic            running;
    logic [DW:0]     trial;

    // Partial remainder shifted left with the next dividend bit brought in
    always_comb begin
        trial = {rem, quotient[DW-1]};
    end

    // The quotient register doubles as the dividend shift register: dividend
    // bits leave from the top while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (!rst) begin
            quotient <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            valid    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                dvs <= divisor;
                rem <= '0;
                if (divisor == '0) begin
                    quotient <= '1;
                    div_zero <= 1'b1;
                    valid    <= 1'b1;
                    running  <= 1'b0;
                end else begin
                    quotient <= dividend;
                    div_zero <= 1'b0;
                    cnt      <= CNTW'(DW);
                    running  <= 1'b1;
                end
            end else if (running) begin
                if (trial >= {1'b0, dvs}) begin
                    rem      <= trial[DW-1:0] - dvs;
                    quotient <= {quotient[DW-2:0], 1'b1};
                end else begin
                    rem      <= trial[DW-1:0];
                    quotient <= {quotient[DW-2:0], 1'b0};
                end
                cnt <= cnt - 1'b1;
                if (cnt == CNTW'(1)) begin
                    running <= 1'b0;
                    valid   <= 1'b1;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/sched_dp_engine.sv
// sched_dp_engine
//   Programmable datapath: one shared ALU (add/sub/and/or) and one MUL/DIV
//   unit write an NREG-entry register file. Operand selects pick a captured
//   input, a register, or zero. A sequencer runs a loadable microprogram one
//   instruction per step until an instruction with last set (or the final
//   program slot), then pulses done.
//   Build option SCHED_DP_DIV_EN: when defined, mul_op=1 divides through the
//   iterative divider (extra wait state); when undefined, mul_op=1 multiplies
//   and div_zero is constant 0.
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   in_data     NIN packed DW-bit inputs, snapshotted at start
//   start       begin a run (ignored unless idle)
//   prog_we     program memory write strobe (ignored while busy)
//   prog_addr   program write address
//   prog_wdata  instruction word to write
//   busy        run in progress
//   done        one-cycle pulse at run completion
//   result      last value written by a result instruction
//   div_zero    sticky divide-by-zero flag for the current run
module sched_dp_engine
    import sched_dp_pkg::*;
#(
    parameter int  DW     = 32,
    parameter int  NIN    = 7,
    parameter int  NREG   = 8,
    parameter int  PDEPTH = 16,
    localparam int SELW   = sel_width(NIN, NREG),
    localparam int RW     = $clog2(NREG),
    localparam int PW     = $clog2(PDEPTH),
    localparam int CW     = instr_width(SELW, RW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NIN*DW-1:0] in_data,
    input  logic              start,
    input  logic              prog_we,
    input  logic [PW-1:0]     prog_addr,
    input  logic [CW-1:0]     prog_wdata,
    output logic              busy,
    output logic              done,
    output logic [DW-1:0]     result,
    output logic              div_zero
);

    localparam int NSRC      = 1 << SELW;
    localparam int O_LAST    = field_off(F_LAST,    SELW, RW);
    localparam int O_RES_SRC = field_off(F_RES_SRC, SELW, RW);
    localparam int O_RES_WE  = field_off(F_RES_WE,  SELW, RW);
    localparam int O_MUL_DST = field_off(F_MUL_DST, SELW, RW);
    localparam int O_MUL_WE  = field_off(F_MUL_WE,  SELW, RW);
    localparam int O_ALU_DST = field_off(F_ALU_DST, SELW, RW);
    localparam int O_ALU_WE  = field_off(F_ALU_WE,  SELW, RW);
    localparam int O_MUL_OP  = field_off(F_MUL_OP,  SELW, RW);
    localparam int O_ALU_OP  = field_off(F_ALU_OP,  SELW, RW);
    localparam int O_MUL_S2  = field_off(F_MUL_S2,  SELW, RW);
    localparam int O_MUL_S1  = field_off(F_MUL_S1,  SELW, RW);
    localparam int O_ALU_S2  = field_off(F_ALU_S2,  SELW, RW);
    localparam int O_ALU_S1  = field_off(F_ALU_S1,  SELW, RW);

    state_e        state;
    logic [PW-1:0] pc;
    logic [DW-1:0] regs     [NREG];
    logic [DW-1:0] in_cap   [NIN];
    logic [CW-1:0] prog_mem [PDEPTH];
    logic [DW-1:0] src      [NSRC];

    logic [CW-1:0]   instr;
    logic [SELW-1:0] alu_s1, alu_s2, mul_s1, mul_s2;
    alu_op_e         alu_op;
    mul_op_e         mul_op;
    logic            alu_we, mul_we, res_we, last;
    logic [RW-1:0]   alu_dst, mul_dst, res_src;

    logic [DW-1:0] alu_a, alu_b, mul_a, mul_b;
    logic [DW-1:0] alu_res, product, mul_res;
    logic          commit;

    assign instr   = prog_mem[pc];
    assign alu_s1  = instr[O_ALU_S1 +: SELW];
    assign alu_s2  = instr[O_ALU_S2 +: SELW];
    assign mul_s1  = instr[O_MUL_S1 +: SELW];
    assign mul_s2  = instr[O_MUL_S2 +: SELW];
    assign alu_op  = alu_op_e'(instr[O_ALU_OP +: 2]);
    assign mul_op  = mul_op_e'(instr[O_MUL_OP]);
    assign alu_we  = instr[O_ALU_WE];
    assign alu_dst = instr[O_ALU_DST +: RW];
    assign mul_we  = instr[O_MUL_WE];
    assign mul_dst = instr[O_MUL_DST +: RW];
    assign res_we  = instr[O_RES_WE];
    assign res_src = instr[O_RES_SRC +: RW];
    assign last    = instr[O_LAST];

    // Operand source table: captured inputs, then registers, then zeros for
    // any select codes beyond the populated range.
    always_comb begin
        for (int s = 0; s < NSRC; s++) src[s] = '0;
        for (int k = 0; k < NIN; k++) src[k] = in_cap[k];
        for (int r = 0; r < NREG; r++) src[NIN + r] = regs[r];
    end

    assign alu_a   = src[alu_s1];
    assign alu_b   = src[alu_s2];
    assign mul_a   = src[mul_s1];
    assign mul_b   = src[mul_s2];
    assign product = mul_a * mul_b;

    // Shared ALU, unsigned and wrapping
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            default: alu_res = '0;
        endcase
    end

`ifdef SCHED_DP_DIV_EN
    logic          div_start;
    logic [DW-1:0] div_quot;
    logic          div_valid;
    logic          div_dz;
    logic          div_zero_q;

    // A divide parks the sequencer in DIVW; the instruction commits only
    // once the quotient is back, so nothing else moves meanwhile.
    assign div_start = (state == ST_RUN) && mul_we && (mul_op == MUL_DIV);
    assign commit    = ((state == ST_RUN) && !div_start) ||
                       ((state == ST_DIVW) && div_valid);
    assign mul_res   = (mul_op == MUL_DIV) ? div_quot : product;
    assign div_zero  = div_zero_q;

    sched_dp_divider #(.DW(DW)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (mul_a),
        .divisor  (mul_b),
        .quotient (div_quot),
        .valid    (div_valid),
        .div_zero (div_dz)
    );
`else
    logic unused_mul_op;

    assign commit        = (state == ST_RUN);
    assign mul_res       = product;
    assign div_zero      = 1'b0;
    assign unused_mul_op = mul_op;
`endif

    // Program memory is deliberately not reset; writes are locked out while a
    // run is in flight so the executing program cannot change under it.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            prog_mem[prog_addr] <= prog_wdata;
        end
    end

    // Sequencer and architectural state. Register writes use non-blocking
    // assignment order so that a MUL write to the same destination as the
    // ALU write lands last and wins, and the result capture reads the value
    // from before this step's commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            for (int k = 0; k < NIN; k++) in_cap[k] <= '0;
`ifdef SCHED_DP_DIV_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NIN; k++) in_cap[k] <= in_data[k*DW +: DW];
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
`ifdef SCHED_DP_DIV_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end
`ifdef SCHED_DP_DIV_EN
                ST_RUN: begin
                    if (div_start) state <= ST_DIVW;
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: ;
            endcase

            if (commit) begin
                if (alu_we) regs[alu_dst] <= alu_res;
                if (mul_we) regs[mul_dst] <= mul_res;
                if (res_we) result <= regs[res_src];
`ifdef SCHED_DP_DIV_EN
                if ((state == ST_DIVW) && div_dz) div_zero_q <= 1'b1;
`endif
                if (last || (pc == PW'(PDEPTH - 1))) begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    pc    <= pc + 1'b1;
                    state <= ST_RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_sched_dp_engine.sv
// tb_sched_dp_engine
//   Scoreboard bench for sched_dp_engine. Each run's expected result,
//   div_zero and busy length come from a small instruction-level model and
//   are queued when the run is started, then popped when done pulses.
module tb_sched_dp_engine;

    localparam int DW     = 32;
    localparam int NIN    = 7;
    localparam int NREG   = 8;
    localparam int PDEPTH = 16;

`ifdef SCHED_DP_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NIN*DW-1:0] in_data;
    logic              start;
    logic              prog_we;
    logic [3:0]        prog_addr;
    logic [31:0]       prog_wdata;
    logic              busy;
    logic              done;
    logic [DW-1:0]     result;
    logic              div_zero;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sbQ[$];
    logic [31:0] mProg [PDEPTH];
    logic [31:0] mIn   [NIN];
    logic [31:0] mRegs [NREG];
    logic [31:0] mResult;
    int          vecCount  = 0;
    int          missCount = 0;

    sched_dp_engine dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int as1, input int as2, input int ms1, input int ms2,
                                        input int aop, input int mop, input int awe, input int ad,
                                        input int mwe, input int md, input int rwe, input int rs,
                                        input int lst);
        return {4'(as1), 4'(as2), 4'(ms1), 4'(ms2), 2'(aop), 1'(mop), 1'(awe), 3'(ad),
                1'(mwe), 3'(md), 1'(rwe), 3'(rs), 1'(lst)};
    endfunction

    function automatic logic [31:0] srcVal(input logic [3:0] s);
        if (s < 4'd7) return mIn[3'(s)];
        else if (s < 4'd15) return mRegs[3'(s - 4'd7)];
        else return '0;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < NREG; r++) mRegs[r] = '0;
        mResult = '0;
    endtask

    // Instruction-level reference: runs the program on the model state and
    // reports the final result, div_zero and number of busy cycles.
    task automatic modelRun(input string tag, output exp_t e);
        logic [31:0] w, a1, a2, m1, m2, aluV, mulV;
        int          cyc = 0;
        logic        dz  = 1'b0;
        for (int pc = 0; pc < PDEPTH; pc++) begin
            w  = mProg[pc];
            a1 = srcVal(w[31:28]);
            a2 = srcVal(w[27:24]);
            m1 = srcVal(w[23:20]);
            m2 = srcVal(w[19:16]);
            case (w[15:14])
                2'b00:   aluV = a1 + a2;
                2'b01:   aluV = a1 - a2;
                2'b10:   aluV = a1 & a2;
                default: aluV = a1 | a2;
            endcase
            cyc++;
            if (DIV_ON && w[13] && w[8]) begin
                if (m2 == 0) begin
                    mulV = '1;
                    dz   = 1'b1;
                    cyc += 1;
                end else begin
                    mulV = m1 / m2;
                    cyc += DW + 1;
                end
            end else begin
                mulV = m1 * m2;
            end
            if (w[4])  mResult = mRegs[w[3:1]];
            if (w[12]) mRegs[w[11:9]] = aluV;
            if (w[8])  mRegs[w[7:5]] = mulV;
            if (w[0]) break;
        end
        e.tag = tag;
        e.res = mResult;
        e.dz  = dz;
        e.cyc = cyc;
    endtask

    task automatic clearProg();
        for (int a = 0; a < PDEPTH; a++) mProg[a] = '0;
    endtask

    task automatic setInputs(input logic [31:0] i0, input logic [31:0] i1,
                             input logic [31:0] i2, input logic [31:0] i3);
        for (int k = 0; k < NIN; k++) mIn[k] = '0;
        mIn[0] = i0;
        mIn[1] = i1;
        mIn[2] = i2;
        mIn[3] = i3;
    endtask

    task automatic loadProg();
        for (int a = 0; a < PDEPTH; a++) begin
            prog_we    = 1'b1;
            prog_addr  = 4'(a);
            prog_wdata = mProg[a];
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    // Queue the model's prediction and pulse start for one cycle
    task automatic applyStimulus(input string tag);
        exp_t e;
        for (int k = 0; k < NIN; k++) in_data[k*DW +: DW] = mIn[k];
        modelRun(tag, e);
        sbQ.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles until done, optionally poking start/prog_we mid-run
    // and start in the done cycle, then scores the popped prediction.
    task automatic waitDone(input int injectAt, input bit startInDone);
        exp_t e;
        int   busyCnt = 0;
        int   cyc     = 0;
        bit   got     = 1'b0;
        while (!got && cyc < 600) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busyCnt++;
                if (busy && busyCnt == injectAt) begin
                    start      = 1'b1;
                    prog_we    = 1'b1;
                    prog_addr  = 4'd10;
                    prog_wdata = enc(0,0,0,0,0,0,0,0,0,0,0,0,1);
                end
                @(negedge clk);
                start   = 1'b0;
                prog_we = 1'b0;
                cyc++;
            end
        end
        e = sbQ.pop_front();
        checkOutput({e.tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            checkOutput({e.tag, "_result"}, result, e.res);
            checkOutput({e.tag, "_divzero"}, 32'(div_zero), 32'(e.dz));
            checkOutput({e.tag, "_busy_cycles"}, 32'(busyCnt), 32'(e.cyc));
            checkOutput({e.tag, "_busy_in_done"}, 32'(busy), 32'd0);
            if (startInDone) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checkOutput({e.tag, "_done_width"}, 32'(done), 32'd0);
            checkOutput({e.tag, "_idle_after"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst        = 1'b0;
        in_data    = '0;
        start      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_divzero", 32'(div_zero), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // r0 = i1*i2, r1 = r0+i3, result r1
        clearProg();
        mProg[0] = enc(0,0,1,2, 0,0, 0,0, 1,0, 0,0, 0);
        mProg[1] = enc(7,3,0,0, 0,0, 1,1, 0,0, 0,0, 0);
        mProg[2] = enc(0,0,0,0, 0,0, 0,0, 0,0, 1,1, 1);
        loadProg();
        setInputs(0, 3, 4, 5);
        applyStimulus("mac");
        waitDone(-1, 1'b0);

        // r2 = i0 / i1, result r2
        clearProg();
        mProg[0] = enc(0,0,0,1, 0,1, 0,0, 1,2, 0,0, 0);
        mProg[1] = enc(0,0,0,0, 0,0, 0,0, 0,0, 1,2, 1);
        loadProg();
        setInputs(100, 7, 0, 0);
        applyStimulus("div100_7");
        waitDone(-1, 1'b0);
        setInputs(9, 0, 0, 0);
        applyStimulus("div9_0");
        waitDone(-1, 1'b0);
        setInputs(100, 7, 0, 0);
        applyStimulus("div_dz_clear");
        waitDone(-1, 1'b0);

        // ALU and MUL both target r3; MUL must win
        clearProg();
        mProg[0] = enc(0,1,0,1, 0,0, 1,3, 1,3, 0,0, 0);
        mProg[1] = enc(0,0,0,0, 0,0, 0,0, 0,0, 1,3, 1);
        loadProg();
        setInputs(2, 3, 0, 0);
        applyStimulus("same_dst");
        waitDone(-1, 1'b0);

        // No last bit anywhere: r0 += i0 and result r0 at every step
        for (int a = 0; a < PDEPTH; a++) mProg[a] = enc(7,0,0,0, 0,0, 1,0, 0,0, 1,0, 0);
        loadProg();
        setInputs(5, 0, 0, 0);
        applyStimulus("no_last");
        waitDone(3, 1'b1);

        // Reset two cycles into a divide run (DIVW when the divider is built)
        clearProg();
        mProg[0] = enc(0,0,0,1, 0,1, 0,0, 1,2, 0,0, 0);
        mProg[4] = enc(0,0,0,0, 0,0, 0,0, 0,0, 1,2, 1);
        loadProg();
        setInputs(100, 7, 0, 0);
        applyStimulus("abort");
        checkOutput("abort_nodone_c1", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_nodone_c2", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_divzero", 32'(div_zero), 32'd0);
        void'(sbQ.pop_front());
        modelReset();
        @(negedge clk);

        // r2 must have been cleared by the reset
        clearProg();
        mProg[0] = enc(0,0,0,0, 0,0, 0,0, 0,0, 1,2, 1);
        loadProg();
        applyStimulus("regs_cleared");
        waitDone(-1, 1'b0);

        clearProg();
        mProg[0] = enc(0,0,1,2, 0,0, 0,0, 1,0, 0,0, 0);
        mProg[1] = enc(7,3,0,0, 0,0, 1,1, 0,0, 0,0, 0);
        mProg[2] = enc(0,0,0,0, 0,0, 0,0, 0,0, 1,1, 1);
        loadProg();
        setInputs(0, 3, 4, 5);
        applyStimulus("mac_after_abort");
        waitDone(-1, 1'b0);

        // Short random programs against the model
        for (int t = 0; t < 4; t++) begin
            int len;
            len = int'($urandom_range(1, 5));
            clearProg();
            for (int a = 0; a < len; a++) begin
                mProg[a]    = $urandom();
                mProg[a][0] = (a == len - 1);
            end
            loadProg();
            for (int k = 0; k < NIN; k++) mIn[k] = $urandom_range(0, 300);
            applyStimulus("rand");
            waitDone(-1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
